pan_mix_scheduler: RTL and testbench

Time-multiplexes one shared `pan` instance across N_CHANNELS voice channels and accumulates the per-channel left/right results into one stereo mix per sample period. On each `sample_tick` it snapshots all channel samples and weights, then issues one channel per clock into the pan pipeline with correct operand skew. It sums the returned left/right products with saturation and emits one stereo sample with a one-cycle valid strobe. It sits between the voice/oscillator bank and the stereo output stage (reverb/DAC path).

---
 rtl/audio_pkg.sv | 41 ++++
 rtl/pan_mix_scheduler_skew.sv | 56 +++++
 rtl/pan_mix_scheduler.sv | 138 +++++++++++++
 tb/tb_pan_mix_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio datapath definitions: sample/weight types, pan latencies,
// scheduler state encoding and the mix saturation helper.
`ifndef SAMPLE_WIDTH
`define SAMPLE_WIDTH 16
`endif
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif

package audio_pkg;

  localparam int FIXED_POINT_BITS = `FIXED_POINT;
  localparam int SAMPLE_W         = `SAMPLE_WIDTH + `FIXED_POINT;

  // Register stages inside the shared pan block.
  localparam int PAN_WEIGHT_LAT = 3;
  localparam int PAN_IN_LAT     = 1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [31:0]         pan_weight_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/pan_mix_scheduler_skew.sv
// Operand skew and result tagging for the shared pan: delays the sample behind
// its weight and marks which pan outputs belong to issued slots.
module pan_skew_pipe #(
  parameter int SW  = 32,
  parameter int PWL = 3,
  parameter int PIL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [SW-1:0] issue_sample,
  output logic [SW-1:0] pan_in,
  output logic          result_valid,
  output logic          last_result
);

  // The final skew stage is the pan_in output register itself.
  localparam int SKEW = PWL - PIL + 1;

  logic [SW-1:0] r_skew [SKEW];
  logic [PWL:0]  r_tag;
  logic          w_shift;

  // Keep shifting while an issued sample is still travelling to pan_in, then
  // hold so pan_in keeps its last value between frames.
  always_comb begin
    w_shift = issue;
    for (int i = 0; i < SKEW - 1; i++) begin
      w_shift = w_shift | r_tag[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= '0;
      for (int i = 0; i < SKEW; i++) begin
        r_skew[i] <= '0;
      end
    end else begin
      r_tag <= {r_tag[PWL-1:0], issue};
      if (issue) begin
        r_skew[0] <= issue_sample;
      end
      if (w_shift) begin
        for (int i = 1; i < SKEW; i++) begin
          r_skew[i] <= r_skew[i-1];
        end
      end
    end
  end

  assign pan_in       = r_skew[SKEW-1];
  assign result_valid = r_tag[PWL];
  assign last_result  = r_tag[PWL] && (r_tag[PWL-1:0] == '0);

endmodule

// File: rtl/pan_mix_scheduler.sv
// Time-multiplexes one shared pan block over N voice channels and sums the
// returned left/right products into one saturated stereo sample per frame.
`ifndef SAMPLE_WIDTH
`define SAMPLE_WIDTH 16
`endif
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif

module pan_mix_scheduler #(
  parameter int N_CHANNELS     = 8,
  parameter int WIDTH          = `SAMPLE_WIDTH,
  parameter int PAN_WEIGHT_LAT = audio_pkg::PAN_WEIGHT_LAT,
  parameter int PAN_IN_LAT     = audio_pkg::PAN_IN_LAT
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        sample_tick,
  input  logic [N_CHANNELS-1:0][WIDTH+`FIXED_POINT-1:0] ch_sample,
  input  logic [N_CHANNELS-1:0][31:0]                 ch_weight,
  input  logic [N_CHANNELS-1:0]                       ch_enable,
  output logic signed [WIDTH+`FIXED_POINT-1:0]        pan_in,
  output audio_pkg::pan_weight_t                      pan_weight,
  input  logic signed [WIDTH+`FIXED_POINT-1:0]        pan_left,
  input  logic signed [WIDTH+`FIXED_POINT-1:0]        pan_right,
  output logic signed [WIDTH+`FIXED_POINT-1:0]        mix_left,
  output logic signed [WIDTH+`FIXED_POINT-1:0]        mix_right,
  output logic                                        mix_valid,
  output logic                                        busy,
  output logic                                        overrun
);

  import audio_pkg::*;

  localparam int SW = WIDTH + `FIXED_POINT;
  localparam int AW = SW + $clog2(N_CHANNELS);
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  sched_state_t                   r_state;
  logic [CW-1:0]                  r_cnt;
  logic signed [AW-1:0]           r_acc_l;
  logic signed [AW-1:0]           r_acc_r;
  logic [N_CHANNELS-1:0][SW-1:0]  r_snap_sample;
  logic [N_CHANNELS-1:0][31:0]    r_snap_weight;
  logic [N_CHANNELS-1:0]          r_snap_en;

  logic                           w_issue;
  logic [SW-1:0]                  w_issue_sample;
  logic [31:0]                    w_issue_weight;
  logic                           w_result_valid;
  logic                           w_last_result;

  // Disabled channels still occupy their slot so frame timing never varies.
  assign w_issue        = (r_state == ST_ISSUE);
  assign w_issue_sample = r_snap_en[r_cnt] ? r_snap_sample[r_cnt] : '0;
  assign w_issue_weight = r_snap_en[r_cnt] ? r_snap_weight[r_cnt] : '0;

  // NOTE: the snapshot has no reset; it is always written at tick capture
  // before any slot reads it, so clearing it would only add reset fanout.
  always_ff @(posedge clk) begin
    if (!rst && sample_tick && (r_state == ST_IDLE)) begin
      r_snap_sample <= ch_sample;
      r_snap_weight <= ch_weight;
      r_snap_en     <= ch_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_acc_l    <= '0;
      r_acc_r    <= '0;
      pan_weight <= '0;
      mix_left   <= '0;
      mix_right  <= '0;
      mix_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= sample_tick && (r_state != ST_IDLE);

      if (w_result_valid) begin
        r_acc_l <= r_acc_l + AW'(pan_left);
        r_acc_r <= r_acc_r + AW'(pan_right);
      end

      case (r_state)
        ST_IDLE: begin
          if (sample_tick) begin
            busy    <= 1'b1;
            r_cnt   <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          pan_weight <= w_issue_weight;
          r_cnt      <= r_cnt + 1'b1;
          if (r_cnt == CW'(N_CHANNELS - 1)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The edge that adds the final tagged result also leaves DRAIN.
          if (w_last_result) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          mix_left  <= SW'(saturate(64'(r_acc_l), SW));
          mix_right <= SW'(saturate(64'(r_acc_r), SW));
          mix_valid <= 1'b1;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pan_skew_pipe #(
    .SW  (SW),
    .PWL (PAN_WEIGHT_LAT),
    .PIL (PAN_IN_LAT)
  ) u_skew (
    .clk          (clk),
    .rst          (rst),
    .issue        (w_issue),
    .issue_sample (w_issue_sample),
    .pan_in       (pan_in),
    .result_valid (w_result_valid),
    .last_result  (w_last_result)
  );

endmodule

// File: tb/tb_pan_mix_scheduler.sv
// Bench for pan_mix_scheduler: a behavioural constant-power pan with the real
// pipeline latencies, and a per-frame reference mix computed from the tick data.
module tb_pan_mix_scheduler;
  import audio_pkg::*;

  localparam int  N   = 8;
  localparam int  SW  = SAMPLE_W;
  localparam int  ONE = 1 << FIXED_POINT_BITS;
  localparam int  LAT = N + 5;
  localparam real PI  = 3.14159265358979;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  sample_tick;
  logic [N-1:0][SW-1:0]  ch_sample;
  logic [N-1:0][31:0]    ch_weight;
  logic [N-1:0]          ch_enable;
  sample_t               pan_in;
  pan_weight_t           pan_weight;
  sample_t               pan_left  = '0;
  sample_t               pan_right = '0;
  sample_t               mix_left;
  sample_t               mix_right;
  logic                  mix_valid;
  logic                  busy;
  logic                  overrun;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pan_mix_scheduler #(.N_CHANNELS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .ch_sample   (ch_sample),
    .ch_weight   (ch_weight),
    .ch_enable   (ch_enable),
    .pan_in      (pan_in),
    .pan_weight  (pan_weight),
    .pan_left    (pan_left),
    .pan_right   (pan_right),
    .mix_left    (mix_left),
    .mix_right   (mix_right),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  // Constant-power law: weight -1..+1 maps to theta 0..pi/2.
  function automatic real gain(input int w, input bit right);
    real x;
    x = real'(w) / real'(ONE);
    if (x > 1.0)  x = 1.0;
    if (x < -1.0) x = -1.0;
    return right ? $sin((x + 1.0) * PI / 4.0) : $cos((x + 1.0) * PI / 4.0);
  endfunction

  function automatic int pan_prod(input int s, input int w, input bit right);
    return $rtoi(real'(s) * gain(w, right));
  endfunction

  // Shared pan block: weight -> theta -> gain -> scaled, sample -> scaled.
  pan_weight_t m_w1 = '0;
  real         m_gl = 0.0;
  real         m_gr = 0.0;
  always @(posedge clk) begin
    m_w1      <= pan_weight;
    m_gl      <= gain(m_w1, 1'b0);
    m_gr      <= gain(m_w1, 1'b1);
    pan_left  <= sample_t'($rtoi(real'(pan_in) * m_gl));
    pan_right <= sample_t'($rtoi(real'(pan_in) * m_gr));
  end

  function automatic sample_t ref_mix(input logic [N-1:0][SW-1:0] s,
                                      input logic [N-1:0][31:0]   w,
                                      input logic [N-1:0]         en,
                                      input bit                   right);
    longint acc, hi, lo;
    acc = 0;
    hi  = (longint'(1) <<< (SW - 1)) - 1;
    lo  = -hi - 1;
    for (int i = 0; i < N; i++)
      if (en[i]) acc += longint'(pan_prod(int'(s[i]), int'(w[i]), right));
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return sample_t'(acc);
  endfunction

  // Called at a negedge; ticks at the next edge and waits (bounded) for mix_valid.
  task automatic run_frame(output sample_t l, output sample_t r, output int lat,
                           output bit busy_start, output bit busy_end, output bit ovr);
    lat = -1; l = '0; r = '0; ovr = 1'b0; busy_end = 1'b1;
    sample_tick = 1'b1;
    @(posedge clk); @(negedge clk);
    sample_tick = 1'b0;
    busy_start  = busy;
    if (overrun) ovr = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (overrun) ovr = 1'b1;
      if (mix_valid) begin
        lat = c; l = mix_left; r = mix_right; busy_end = busy;
        break;
      end
    end
  endtask

  task automatic randomize_channels();
    for (int i = 0; i < N; i++) begin
      ch_sample[i] = ($urandom_range(0, 3) == 0) ? $urandom
                   : 32'(int'($urandom_range(0, 'h40000)) - 'h20000);
      case ($urandom_range(0, 4))
        0:       ch_weight[i] = 32'(-ONE);
        1:       ch_weight[i] = 32'(ONE);
        2:       ch_weight[i] = '0;
        default: ch_weight[i] = 32'(int'($urandom_range(0, 2 * ONE)) - ONE);
      endcase
    end
    ch_enable = N'($urandom);
  endtask

  task automatic test_reset();
    int vc, oc;
    rst = 1'b1; sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if ({pan_in, pan_weight} !== '0) $display("FAIL reset_pan_ports: got %h/%h want 0/0", pan_in, pan_weight); else n_pass++;
    n_total++; if ({mix_left, mix_right} !== '0) $display("FAIL reset_mix: got %0d/%0d want 0/0", mix_left, mix_right); else n_pass++;
    n_total++; if ({mix_valid, busy, overrun} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {mix_valid, busy, overrun}); else n_pass++;
    rst = 1'b0; vc = 0; oc = 0;
    repeat (50) begin
      @(posedge clk); @(negedge clk);
      if (mix_valid) vc++;
      if (overrun) oc++;
    end
    n_total++; if (vc != 0) $display("FAIL idle_mix_valid: got %0d pulses want 0", vc); else n_pass++;
    n_total++; if (busy !== 1'b0 || oc != 0) $display("FAIL idle_busy_overrun: got busy=%b overruns=%0d want 0/0", busy, oc); else n_pass++;
  endtask

  task automatic test_centre();
    sample_t l, r, el, er; int lat; bit b0, b1, ov;
    randomize_channels();
    ch_enable = 8'b0000_0001; ch_sample[0] = 32'h1000; ch_weight[0] = '0;
    el = ref_mix(ch_sample, ch_weight, ch_enable, 1'b0);
    er = ref_mix(ch_sample, ch_weight, ch_enable, 1'b1);
    run_frame(l, r, lat, b0, b1, ov);
    n_total++; if (lat != LAT) $display("FAIL centre_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if (b0 !== 1'b1 || b1 !== 1'b0) $display("FAIL centre_busy: got start=%b end=%b want 1/0", b0, b1); else n_pass++;
    n_total++; if (l !== el) $display("FAIL centre_left: got %0d want %0d", l, el); else n_pass++;
    n_total++; if (r !== er) $display("FAIL centre_right: got %0d want %0d", r, er); else n_pass++;
    n_total++; if (l < 2895 || l > 2897) $display("FAIL centre_level: got %0d want 2896+/-1", l); else n_pass++;
    @(posedge clk); @(negedge clk);
    n_total++; if (mix_valid !== 1'b0 || mix_left !== el) $display("FAIL centre_pulse_hold: got valid=%b left=%0d want 0/%0d", mix_valid, mix_left, el); else n_pass++;
  endtask

  task automatic test_hard_pan();
    sample_t l, r; int lat; bit b0, b1, ov;
    randomize_channels();
    ch_enable = 8'b0000_0011;
    ch_sample[0] = 32'h1000; ch_weight[0] = 32'(-ONE);
    ch_sample[1] = 32'h0800; ch_weight[1] = 32'(ONE);
    run_frame(l, r, lat, b0, b1, ov);
    n_total++; if (l !== 32'sh1000) $display("FAIL hard_left: got %0d want %0d", l, 32'sh1000); else n_pass++;
    n_total++; if (r !== 32'sh0800) $display("FAIL hard_right: got %0d want %0d", r, 32'sh0800); else n_pass++;
  endtask

  task automatic test_saturation();
    sample_t l, r; int lat; bit b0, b1, ov;
    ch_enable = '1;
    for (int i = 0; i < N; i++) begin ch_sample[i] = 32'h7fff_ffff; ch_weight[i] = 32'(-ONE); end
    run_frame(l, r, lat, b0, b1, ov);
    n_total++; if (l !== 32'sh7fff_ffff) $display("FAIL sat_max_left: got %0d want %0d", l, 32'sh7fff_ffff); else n_pass++;
    n_total++; if (r !== 32'sh0) $display("FAIL sat_max_right: got %0d want 0", r); else n_pass++;
    for (int i = 0; i < N; i++) ch_sample[i] = 32'h8000_0000;
    run_frame(l, r, lat, b0, b1, ov);
    n_total++; if (l !== 32'sh8000_0000) $display("FAIL sat_min_left: got %0d want %0d", l, 32'sh8000_0000); else n_pass++;
    n_total++; if (lat != LAT) $display("FAIL sat_latency: got %0d want %0d", lat, LAT); else n_pass++;
  endtask

  task automatic test_random();
    sample_t l, r, el, er; int lat; bit b0, b1, ov;
    for (int f = 0; f < 6; f++) begin
      randomize_channels();
      el = ref_mix(ch_sample, ch_weight, ch_enable, 1'b0);
      er = ref_mix(ch_sample, ch_weight, ch_enable, 1'b1);
      run_frame(l, r, lat, b0, b1, ov);
      n_total++; if (lat != LAT) $display("FAIL random%0d_latency: got %0d want %0d", f, lat, LAT); else n_pass++;
      n_total++; if (l !== el) $display("FAIL random%0d_left: got %0d want %0d", f, l, el); else n_pass++;
      n_total++; if (r !== er) $display("FAIL random%0d_right: got %0d want %0d", f, r, er); else n_pass++;
    end
  endtask

  task automatic test_overrun();
    sample_t l, r, el, er; int vc, oc, vlat; bit ov5;
    randomize_channels();
    el = ref_mix(ch_sample, ch_weight, ch_enable, 1'b0);
    er = ref_mix(ch_sample, ch_weight, ch_enable, 1'b1);
    vc = 0; oc = 0; vlat = -1; ov5 = 1'b0; l = '0; r = '0;
    sample_tick = 1'b1;
    @(posedge clk); @(negedge clk);
    sample_tick = 1'b0;
    randomize_channels();
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) sample_tick = 1'b1;
      @(posedge clk); @(negedge clk);
      sample_tick = 1'b0;
      if (overrun) oc++;
      if (c == 5) ov5 = overrun;
      if (mix_valid) begin vc++; vlat = c; l = mix_left; r = mix_right; end
    end
    n_total++; if (ov5 !== 1'b1 || oc != 1) $display("FAIL overrun_pulse: got at5=%b count=%0d want 1/1", ov5, oc); else n_pass++;
    n_total++; if (vc != 1 || vlat != LAT) $display("FAIL overrun_single_valid: got count=%0d at=%0d want 1 at %0d", vc, vlat, LAT); else n_pass++;
    n_total++; if (l !== el || r !== er) $display("FAIL overrun_snapshot: got %0d/%0d want %0d/%0d", l, r, el, er); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    sample_t l, r, el, er; int vc, lat; bit b0, b1, ov;
    randomize_channels();
    ch_enable = '1;
    vc = 0;
    sample_tick = 1'b1;
    @(posedge clk); @(negedge clk);
    sample_tick = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 6) begin rst = 1'b1; sample_tick = 1'b1; end
      @(posedge clk); @(negedge clk);
      rst = 1'b0; sample_tick = 1'b0;
      if (mix_valid) vc++;
    end
    n_total++; if (vc != 0) $display("FAIL abort_no_valid: got %0d pulses want 0", vc); else n_pass++;
    n_total++; if ({mix_left, mix_right} !== '0) $display("FAIL abort_mix_zero: got %0d/%0d want 0/0", mix_left, mix_right); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    randomize_channels();
    el = ref_mix(ch_sample, ch_weight, ch_enable, 1'b0);
    er = ref_mix(ch_sample, ch_weight, ch_enable, 1'b1);
    run_frame(l, r, lat, b0, b1, ov);
    n_total++; if (lat != LAT) $display("FAIL abort_recover_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if (l !== el || r !== er) $display("FAIL abort_recover_mix: got %0d/%0d want %0d/%0d", l, r, el, er); else n_pass++;
  endtask

  task automatic test_back_to_back();
    sample_t l, r, el, er; int lat; bit b0, b1, ov;
    randomize_channels();
    run_frame(l, r, lat, b0, b1, ov);
    randomize_channels();
    el = ref_mix(ch_sample, ch_weight, ch_enable, 1'b0);
    er = ref_mix(ch_sample, ch_weight, ch_enable, 1'b1);
    run_frame(l, r, lat, b0, b1, ov);
    n_total++; if (ov !== 1'b0 || b0 !== 1'b1) $display("FAIL b2b_accept: got overrun=%b busy=%b want 0/1", ov, b0); else n_pass++;
    n_total++; if (lat != LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if (l !== el || r !== er) $display("FAIL b2b_mix: got %0d/%0d want %0d/%0d", l, r, el, er); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sample_tick = 1'b0;
    ch_sample = '0; ch_weight = '0; ch_enable = '0;
    test_reset();
    test_centre();
    test_hard_pan();
    test_saturation();
    test_random();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
